// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 pipeline.
// Fetch-side definitions used by fetch_stage and pc_reg.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_INC    = 4;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect load, hold and sequential increment.
// Also keeps a sticky flag for redirect targets that were not word aligned.
module pc_reg
  import core_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_hold,
  input  logic [PC_W-1:0] i_tgt,
  output logic [PC_W-1:0] o_pc,
  output logic            o_misaligned
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  logic [PC_W-1:0] r_pc;
  logic            r_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= '0;
      r_mis <= 1'b0;
    end else if (i_load) begin
      r_pc  <= {i_tgt[PC_W-1:2], 2'b00};
      r_mis <= r_mis | (|i_tgt[1:0]);
    end else if (!i_hold) begin
      r_pc <= r_pc + INC;
    end
  end

  assign o_pc         = r_pc;
  assign o_misaligned = r_mis;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, IF/ID register, redirect squash and halt freeze.
// Only RUN reacts to PcSel/Stall; HALTED is left by reset alone.
module fetch_stage
  import core_pkg::*;
#(
  parameter int          PC_W      = 9,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt,
  input  logic            Stall,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Flush,
  output logic            Halted,
  output logic            Misaligned,
  output logic [31:0]     FetchCount
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic            w_run;
  logic            w_redir;
  logic            w_adv;
  logic [PC_W-1:0] w_pc;
  logic            w_unused;

  logic [PC_W-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;
  logic            r_flush;
  logic [31:0]     r_count;

  assign w_run    = (r_state == RUN);
  assign w_redir  = w_run & PcSel;
  assign w_adv    = w_run & ~PcSel & ~Stall;
  assign w_unused = ^BrPC[31:PC_W];

  pc_reg #(
    .PC_W(PC_W)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_redir),
    .i_hold      (~w_adv),
    .i_tgt       (BrPC[PC_W-1:0]),
    .o_pc        (w_pc),
    .o_misaligned(Misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_redir && Halt) w_next = HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_flush      <= 1'b0;
      r_count      <= '0;
    end else if (w_redir) begin
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_flush      <= 1'b1;
    end else if (w_adv) begin
      r_ifid_pc    <= w_pc;
      r_ifid_instr <= imem_rdata;
      r_ifid_valid <= 1'b1;
      r_flush      <= 1'b0;
      r_count      <= r_count + 32'd1;
    end else begin
      r_flush <= 1'b0;
    end
  end

  assign imem_addr  = w_pc;
  assign IfId_PC    = r_ifid_pc;
  assign IfId_Instr = r_ifid_instr;
  assign IfId_Valid = r_ifid_valid;
  assign Flush      = r_flush;
  assign Halted     = (r_state == HALTED);
  assign FetchCount = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expected snapshots are queued per edge
// and a negedge monitor compares them against the DUT outputs.
module tb_fetch_stage;

  localparam int PC_W = 9;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [8:0]  pc;
    logic [8:0]  ifpc;
    logic [31:0] instr;
    logic        v;
    logic        f;
    logic        h;
    logic        m;
    logic [31:0] cnt;
  } snap_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt;
  logic            Stall;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            Flush;
  logic            Halted;
  logic            Misaligned;
  logic [31:0]     FetchCount;

  snap_t q[$];
  int    n_vec = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'hA0 + {23'd0, imem_addr};

  fetch_stage #(.PC_W(PC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Halt       (Halt),
    .Stall      (Stall),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .IfId_PC    (IfId_PC),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Flush      (Flush),
    .Halted     (Halted),
    .Misaligned (Misaligned),
    .FetchCount (FetchCount)
  );

  function automatic snap_t mk(input logic [8:0] pc, input logic [8:0] ifpc,
                               input logic [31:0] instr, input logic v,
                               input logic f, input logic h, input logic m,
                               input logic [31:0] cnt);
    snap_t s;
    s.pc = pc; s.ifpc = ifpc; s.instr = instr; s.v = v;
    s.f = f; s.h = h; s.m = m; s.cnt = cnt;
    return s;
  endfunction

  task automatic step(input logic rst, input logic sel, input logic hlt,
                      input logic stl, input logic [31:0] br, input snap_t e);
    @(negedge clk);
    reset = rst; PcSel = sel; Halt = hlt; Stall = stl; BrPC = br;
    @(posedge clk);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e, a;
      e = q.pop_front();
      a = mk(imem_addr, IfId_PC, IfId_Instr, IfId_Valid, Flush, Halted,
             Misaligned, FetchCount);
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got pc=%h ifpc=%h ins=%h v%b f%b h%b m%b cnt=%0d, want pc=%h ifpc=%h ins=%h v%b f%b h%b m%b cnt=%0d",
                 n_vec, a.pc, a.ifpc, a.instr, a.v, a.f, a.h, a.m, a.cnt,
                 e.pc, e.ifpc, e.instr, e.v, e.f, e.h, e.m, e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b1; PcSel = 1'b0; Halt = 1'b0; Stall = 1'b0; BrPC = '0;
    // reset
    step(1, 0, 0, 0, 0,        mk(9'h000, 9'h000, NOP, 0, 0, 0, 0, 0));
    // free run
    step(0, 0, 0, 0, 0,        mk(9'h004, 9'h000, 32'hA0, 1, 0, 0, 0, 1));
    step(0, 0, 0, 0, 0,        mk(9'h008, 9'h004, 32'hA4, 1, 0, 0, 0, 2));
    // stall two cycles at PC=8
    step(0, 0, 0, 1, 0,        mk(9'h008, 9'h004, 32'hA4, 1, 0, 0, 0, 2));
    step(0, 0, 0, 1, 0,        mk(9'h008, 9'h004, 32'hA4, 1, 0, 0, 0, 2));
    step(0, 0, 0, 0, 0,        mk(9'h00C, 9'h008, 32'hA8, 1, 0, 0, 0, 3));
    step(0, 0, 0, 0, 0,        mk(9'h010, 9'h00C, 32'hAC, 1, 0, 0, 0, 4));
    // redirect to 0x40 while stalled
    step(0, 1, 0, 1, 32'h40,   mk(9'h040, 9'h000, NOP, 0, 1, 0, 0, 4));
    step(0, 0, 0, 0, 0,        mk(9'h044, 9'h040, 32'hE0, 1, 0, 0, 0, 5));
    // back-to-back redirects, second one misaligned
    step(0, 1, 0, 0, 32'h100,  mk(9'h100, 9'h000, NOP, 0, 1, 0, 0, 5));
    step(0, 1, 0, 0, 32'h123,  mk(9'h120, 9'h000, NOP, 0, 1, 0, 1, 5));
    step(0, 0, 0, 0, 0,        mk(9'h124, 9'h120, 32'h1C0, 1, 0, 0, 1, 6));
    // aligned redirect with upper bits set; misaligned stays sticky
    step(0, 1, 0, 0, 32'hFFFF_F1F0, mk(9'h1F0, 9'h000, NOP, 0, 1, 0, 1, 6));
    step(0, 0, 0, 0, 0,        mk(9'h1F4, 9'h1F0, 32'h290, 1, 0, 0, 1, 7));
    step(0, 0, 0, 0, 0,        mk(9'h1F8, 9'h1F4, 32'h294, 1, 0, 0, 1, 8));
    step(0, 0, 0, 0, 0,        mk(9'h1FC, 9'h1F8, 32'h298, 1, 0, 0, 1, 9));
    // PC wrap
    step(0, 0, 0, 0, 0,        mk(9'h000, 9'h1FC, 32'h29C, 1, 0, 0, 1, 10));
    step(0, 0, 0, 0, 0,        mk(9'h004, 9'h000, 32'hA0, 1, 0, 0, 1, 11));
    // reset mid-stall
    step(1, 0, 0, 1, 0,        mk(9'h000, 9'h000, NOP, 0, 0, 0, 0, 0));
    // Halt without PcSel is ignored
    step(0, 0, 1, 0, 32'h80,   mk(9'h004, 9'h000, 32'hA0, 1, 0, 0, 0, 1));
    step(0, 0, 0, 0, 0,        mk(9'h008, 9'h004, 32'hA4, 1, 0, 0, 0, 2));
    // halt to 0x30
    step(0, 1, 1, 0, 32'h30,   mk(9'h030, 9'h000, NOP, 0, 1, 1, 0, 2));
    for (int i = 0; i < 10; i++) begin
      step(0, 1'(i % 2), 1'(i % 3 == 0), 1'(i % 4 == 1), 32'h60 + 32'(i * 4),
           mk(9'h030, 9'h000, NOP, 0, 0, 1, 0, 2));
    end
    // reset during a redirect clears halt
    step(1, 1, 1, 1, 32'h50,   mk(9'h000, 9'h000, NOP, 0, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0,        mk(9'h004, 9'h000, 32'hA0, 1, 0, 0, 0, 1));
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected snapshots never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- PC register and IF/ID pipeline register for the pipelined RV32 core.
- Sits directly downstream of the EX-stage branch resolution. It consumes the redirect select and redirect target, and drives the instruction-memory address.
- It presents the fetched instruction to ID, squashes wrong-path instructions on a redirect, and freezes fetch after a halt.

Parameters:
- PC_W, 9, width of the PC and of the instruction-memory byte address.
- NOP_INSTR, 32'h00000013, instruction injected into IF/ID on reset or flush (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- PcSel  input  1  from EX: 1 = redirect fetch to BrPC this cycle.
- BrPC  input  32  from EX: redirect target (branch, jal, jalr, or halt self-loop).
- Halt  input  1  from EX: halt instruction resolved in EX (qualifies PcSel).
- Stall  input  1  from hazard unit: hold PC and IF/ID (load-use).
- imem_addr  output  PC_W  byte address to instruction memory (combinational read, same-cycle data).
- imem_rdata  input  32  instruction word at imem_addr.
- IfId_PC  output  PC_W  PC of the instruction in IF/ID.
- IfId_Instr  output  32  instruction in IF/ID.
- IfId_Valid  output  1  IF/ID holds a real (non-squashed) instruction.
- Flush  output  1  registered; tells ID/EX to squash its contents next cycle.
- Halted  output  1  core halted; fetch frozen.
- Misaligned  output  1  sticky: a redirect target had BrPC[1:0] != 0.
- FetchCount  output  32  number of instructions accepted into IF/ID with Valid=1.

Behaviour:
- imem_addr = PC at all times (purely combinational from the PC register).
- Reset (takes precedence over everything):
  - PC=0, IfId_PC=0, IfId_Instr=NOP_INSTR, IfId_Valid=0.
  - Flush=0, Halted=0, Misaligned=0, FetchCount=0.
  - State = RUN.
- States: RUN, HALTED.
- RUN, per-cycle priority: redirect > stall > advance.
- Redirect (PcSel=1), including when Stall=1:
  - PC <= {BrPC[PC_W-1:2], 2'b00}; upper bits of BrPC beyond PC_W are discarded.
  - IfId_Instr <= NOP_INSTR, IfId_Valid <= 0, IfId_PC <= 0.
  - Flush <= 1 for exactly one cycle.
  - Misaligned <= 1 if BrPC[1:0] != 0; it stays set until reset.
  - If Halt=1, next state = HALTED.
- Stall (Stall=1, PcSel=0): PC, IfId_* and FetchCount all hold. Flush <= 0.
- Advance:
  - PC <= PC + 4, wrapping modulo 2^PC_W.
  - IfId_PC <= PC, IfId_Instr <= imem_rdata, IfId_Valid <= 1.
  - FetchCount <= FetchCount + 1, wrapping at 2^32.
  - Flush <= 0.
- Redirect latency: the target instruction appears in IF/ID with Valid=1 two edges after the PcSel edge. That is one edge to load PC and one edge to latch imem_rdata.
- HALTED:
  - PC holds the halt target.
  - IF/ID holds NOP_INSTR with Valid=0.
  - FetchCount frozen; Flush=0; Halted=1.
  - PcSel and Stall are ignored.
  - The state is left only by reset.
- Halt=1 with PcSel=0 is ignored; the halt is qualified by PcSel.
- Back-to-back redirects on consecutive cycles: each one reloads the PC and re-asserts Flush. The last target wins.
- Reset asserted mid-stall or mid-flush: all state returns to its reset values on that edge, with no partial update.

Decomposition:
- Shared package core_pkg holds:
  - NOP_INSTR constant;
  - fetch_state_t enum {RUN, HALTED};
  - the PC increment constant (4).
- One natural sub-module: pc_reg (PC register with load/hold/increment, alignment masking, and the sticky misaligned flag).
- The IF/ID register, the state machine and the counter stay in fetch_stage.

Test Plan:
- Reset then 4 free-run cycles with imem returning 0xA0+addr: imem_addr 0,4,8,12. IF/ID shows (0,0xA0),(4,0xA4),(8,0xA8) with Valid=1. FetchCount=3 after the third edge.
- Stall held 2 cycles at PC=8: PC stays 8, IfId_PC stays 4, FetchCount unchanged. Advance resumes on the first cycle with Stall=0.
- PcSel=1, BrPC=0x40 while PC=0x10, with Stall=1 simultaneously: PC=0x40 next cycle, IfId_Valid=0, Flush=1 for one cycle. IfId_PC=0x40 with Valid=1 one cycle later.
- PcSel=1, BrPC=0x123: PC=0x120 and Misaligned=1. Misaligned stays 1 after further normal redirects, until reset.
- PcSel=1, Halt=1, BrPC=0x30: Halted=1, PC fixed at 0x30, IfId_Valid=0 and FetchCount frozen for 10 cycles despite PcSel/Stall toggling. Reset then clears everything to reset values.
- PC at 0x1FC (PC_W=9) advancing: PC wraps to 0x000, and IfId_PC=0x1FC is captured correctly.
